// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg: shared bus widths, direction/flag constants and slave FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_YES   = 1'b1;
  localparam logic BUS_NO    = 1'b0;

  typedef enum logic [1:0] {
    BUS_SLV_IDLE = 2'd0,
    BUS_SLV_WAIT = 2'd1,
    BUS_SLV_RESP = 2'd2,
    BUS_SLV_DONE = 2'd3
  } bus_slv_state_e;

endpackage

`default_nettype wire

// File: rtl/spm_ram.sv
// ---------------------------------------------------------------------------
// spm_ram: single-port synchronous RAM with registered read, no content reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spm_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bus_spm_slave.sv
// ---------------------------------------------------------------------------
// bus_spm_slave: scratch-pad memory bus responder with programmable wait states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_spm_slave
  import bus_pkg::*;
#(
  parameter int              ADDR_W      = BUS_ADDR_W,
  parameter int              DATA_W      = BUS_DATA_W,
  parameter int              DEPTH_LOG2  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
  parameter int              WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_as,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rw,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic              bus_ready,
  output logic [DATA_W-1:0] bus_rd_data,
  output logic              busy
);

  bus_slv_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  rw_q, rw_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  ready_q, ready_d;

  logic                  hit;
  logic                  ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  cur_rw;
  logic                  unused_as;

  assign unused_as = bus_as;
  assign hit = (bus_addr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    unique case (state_q)
      BUS_SLV_IDLE: begin
        if (bus_req && hit) begin
          idx_d   = bus_addr[DEPTH_LOG2-1:0];
          rw_d    = bus_rw;
          wdata_d = bus_wr_data;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? BUS_SLV_RESP : BUS_SLV_WAIT;
        end
      end
      BUS_SLV_WAIT: begin
        // Abort takes priority over the final wait cycle so no write commits.
        if (!bus_req) begin
          state_d = BUS_SLV_IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = BUS_SLV_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BUS_SLV_RESP: state_d = BUS_SLV_DONE;
      BUS_SLV_DONE: begin
        if (!bus_req) begin
          state_d = BUS_SLV_IDLE;
        end
      end
      default: state_d = BUS_SLV_IDLE;
    endcase
    ready_d = (state_d == BUS_SLV_RESP);
  end

  // With zero wait states the RAM access happens on the accept edge, before
  // the latched fields exist, so the live bus fields are used there.
  always_comb begin
    ram_addr  = idx_q;
    ram_wdata = wdata_q;
    cur_rw    = rw_q;
    if (state_q == BUS_SLV_IDLE) begin
      ram_addr  = bus_addr[DEPTH_LOG2-1:0];
      ram_wdata = bus_wr_data;
      cur_rw    = bus_rw;
    end
    ram_we = ready_d && (cur_rw == BUS_WRITE) && !rst;
    ram_re = ready_d && (cur_rw == BUS_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_SLV_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end

  spm_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_spm_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus_ready   = ready_q;
  assign bus_rd_data = ready_q ? ram_rdata : '0;
  assign busy        = (state_q != BUS_SLV_IDLE);

endmodule

`default_nettype wire
